// File: rtl/ram_arbiter.sv
// One-transaction-at-a-time scheduler for the shared SDRAM port: DMA, CPU and tape
// requesters, with CPU writes to the ROM bank dropped and a starvation guard for tape.
module ram_arbiter #(
    parameter logic [8:0] ROM_BANK     = 9'h017,
    parameter logic [7:0] STARVE_LIMIT = 8'd64
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [24:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    input  logic        tape_req,
    input  logic [24:0] tape_addr,
    output logic        tape_ack,
    output logic [7:0]  tape_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [24:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic        dma_active,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_we,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_DMA, G_TAPE, G_CPU} grant_t;

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        we_q, we_d;
    logic [7:0]  tape_dout_q, tape_dout_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [7:0]  starve_q, starve_d;

    grant_t      winner;
    logic        rom_drop;
    logic        tape_first;

    // Tape jumps ahead of the CPU only once it has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        tape_first = (starve_q == STARVE_LIMIT);
        winner     = G_NONE;
        if (dma_req)                     winner = G_DMA;
        else if (tape_first && tape_req) winner = G_TAPE;
        else if (cpu_req)                winner = G_CPU;
        else if (tape_req)               winner = G_TAPE;
        rom_drop = (winner == G_CPU) && cpu_we && (cpu_addr[24:16] == ROM_BANK);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= G_NONE;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            we_q        <= 1'b0;
            tape_dout_q <= '0;
            cpu_dout_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            we_q        <= we_d;
            tape_dout_q <= tape_dout_d;
            cpu_dout_q  <= cpu_dout_d;
            starve_q    <= starve_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (winner != G_NONE) state_d = rom_drop ? S_DONE : S_ISSUE;
            S_ISSUE: if (mem_ready) state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT:  if (mem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        we_d        = we_q;
        tape_dout_d = tape_dout_q;
        cpu_dout_d  = cpu_dout_q;

        if (state_q == S_IDLE) begin
            unique case (winner)
                G_DMA: begin
                    grant_d    = G_DMA;
                    mem_addr_d = dma_addr;
                    mem_din_d  = dma_din;
                    we_d       = dma_we;
                end
                G_TAPE: begin
                    grant_d    = G_TAPE;
                    mem_addr_d = tape_addr;
                    mem_din_d  = '0;
                    we_d       = 1'b0;
                end
                G_CPU: begin
                    grant_d    = G_CPU;
                    mem_addr_d = cpu_addr;
                    mem_din_d  = cpu_din;
                    we_d       = cpu_we;
                end
                default: ;
            endcase
        end

        // DMA read data has no destination and is simply not captured.
        if (state_q == S_WAIT && mem_ready && !we_q) begin
            if (grant_q == G_TAPE) tape_dout_d = mem_dout;
            if (grant_q == G_CPU)  cpu_dout_d  = mem_dout;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!tape_req || (state_q == S_IDLE && winner == G_TAPE))
            starve_d = '0;
        else if (!(state_q != S_IDLE && grant_q == G_TAPE) && starve_q < STARVE_LIMIT)
            starve_d = starve_q + 8'd1;
    end

    // A strobe is only issued once the controller reports ready on entry to ISSUE.
    always_comb begin
        mem_rd     = (state_q == S_ISSUE) && mem_ready && !we_q;
        mem_we     = (state_q == S_ISSUE) && mem_ready && we_q;
        dma_ack    = (state_q == S_DONE) && (grant_q == G_DMA);
        tape_ack   = (state_q == S_DONE) && (grant_q == G_TAPE);
        cpu_ack    = (state_q == S_DONE) && (grant_q == G_CPU);
        cpu_wait   = reset_n && cpu_req && !cpu_ack;
        dma_active = (state_q != S_IDLE) && (grant_q == G_DMA);
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign tape_dout = tape_dout_q;
    assign cpu_dout  = cpu_dout_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single 8-bit SDRAM controller port between three requesters: the ioctl download/erase DMA, the tape buffer reader and the Z80 memory cycle. It sits between the CPU/tape/ioctl address muxing and the `sram` instance and replaces the combinational priority mux with a sequenced, one-transaction-at-a-time scheduler. It also adds ROM write protection and a starvation guard for the tape reader.

## Interface
Parameters:
- `ROM_BANK`, default 9'h017: value of address bits [24:16] that identifies the ROM region; CPU writes there are dropped.
- `STARVE_LIMIT`, default 8'd64: number of cycles a pending tape request may lose to the CPU before tape is promoted over the CPU.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dma_req` in 1: DMA request, level.
- `dma_we` in 1: DMA write when 1, read when 0.
- `dma_addr` in 25: DMA address.
- `dma_din` in 8: DMA write data.
- `dma_ack` out 1: one-cycle completion pulse for DMA.
- `tape_req` in 1: tape request, level; always a read.
- `tape_addr` in 25: tape address.
- `tape_ack` out 1: one-cycle completion pulse for tape.
- `tape_dout` out 8: tape read data, registered.
- `cpu_req` in 1: CPU request, level.
- `cpu_we` in 1: CPU write when 1, read when 0.
- `cpu_addr` in 25: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse for CPU.
- `cpu_dout` out 8: CPU read data, registered.
- `cpu_wait` out 1: CPU request is pending and not yet acknowledged.
- `dma_active` out 1: high while the arbiter is in a DMA transaction.
- `mem_addr` out 25, `mem_din` out 8: registered command to `sram`.
- `mem_rd` out 1, `mem_we` out 1: one-cycle strobes to `sram`.
- `mem_dout` in 8: `sram` read data.
- `mem_ready` in 1: `sram` idle/done flag.

## Operation
- FSM states: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE: select a winner from the requests sampled this cycle.
  - Priority is DMA > CPU > tape.
  - If the starvation counter equals `STARVE_LIMIT`, the priority is DMA > tape > CPU.
  - The winner's address, write data and write flag are latched into the `mem_*` registers, along with its grant ID. Next state is ISSUE.
  - A CPU write with `cpu_addr[24:16]==ROM_BANK` wins normally but goes straight to DONE with no memory strobe.
- ISSUE: `mem_rd` or `mem_we` is high for exactly this cycle. Next state is GUARD.
- GUARD: one cycle in which `mem_ready` is ignored, covering the `sram` latency before it deasserts ready. Next state is WAIT.
- WAIT: stay until `mem_ready==1`.
  - On that cycle, for a read, capture `mem_dout` into `tape_dout` or `cpu_dout` according to the grant ID. DMA read data is discarded.
  - Next state is DONE.
- DONE: pulse the granted `*_ack` for one cycle, then return to IDLE.
- Requesters hold address and data stable while `req` is high. A requester that keeps `req` high on the cycle after its ack is treated as making a new request.
- Starvation counter, 8 bits:
  - Increments each cycle that `tape_req` is high, tape is not the current grant, and the counter is below `STARVE_LIMIT`. It saturates at `STARVE_LIMIT`.
  - Clears on a tape grant, or whenever `tape_req` is low.
- `cpu_wait` is `cpu_req & ~(state==DONE & grant==CPU)`.
- `dma_active` is high when the grant is DMA and the state is not IDLE.
- Data outputs `tape_dout` and `cpu_dout` hold their value until the next read capture for the same requester.

## Timing
- Reset values: state IDLE; `mem_rd`, `mem_we`, all acks, `cpu_wait` and `dma_active` are 0; `mem_addr`, `mem_din`, `tape_dout`, `cpu_dout` and the starvation counter are 0.
- Reset asserted mid-transaction aborts it immediately: no ack is issued and no strobe is emitted after reset. The requester re-requests after reset.
- Minimum memory latency, with `mem_ready` already high in WAIT:
  - `req` sampled in IDLE at cycle 0.
  - Strobe at cycle 1.
  - Capture at cycle 3.
  - Ack at cycle 4.
- ROM-dropped write: `req` at cycle 0, ack at cycle 1.
- Requests arriving while the FSM is not in IDLE are only considered at the next IDLE. There is no preemption, so DMA waits for the in-flight CPU or tape transaction to finish.
- Simultaneous requests in the same IDLE cycle are resolved by priority only. At most one ack is asserted per cycle.
- The strobe is never issued in a cycle where `mem_ready` is low on entry to ISSUE. If that happens, ISSUE holds without strobing until `mem_ready==1`.

## Test plan
- CPU read at `addr` 25'h050123, `sram` returns 8'hA5 with `mem_ready` low for 5 cycles after GUARD -> one `mem_rd` pulse with `mem_addr`=25'h050123; `cpu_ack` exactly once, 4+5 cycles after the request; `cpu_dout`=8'hA5; `cpu_wait` high from request until the ack.
- CPU write 8'h3C to 25'h170010 (ROM) -> no `mem_we`; `cpu_ack` one cycle after the request. Then a write to 25'h020010 -> `mem_we` with `mem_din`=8'h3C.
- `dma_req`, `cpu_req` and `tape_req` all raised in the same cycle -> DMA is served first (`dma_active`=1), then CPU, then tape; three acks, never coincident.
- `cpu_req` held continuously with back-to-back reads and `tape_req` held -> tape is granted once its counter reaches 64, then the CPU resumes; the counter reads 0 after the tape grant.
- `reset_n` pulled low during WAIT of a CPU read -> all outputs return to reset values asynchronously; no `cpu_ack`. After release, a new request completes normally.
- `sram` holding `mem_ready` low on entry to ISSUE -> the strobe is delayed until ready goes high and is still exactly one cycle wide.
